// File: rtl/irq_pending_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Brief    : Shared constants, state type and clear-mask helper for the
//            interrupt pending arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

   localparam int IRQ_N      = 8;
   localparam int IRQ_CODE_W = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } irq_state_e;

   // One-hot mask with only the bit selected by code set.
   function automatic logic [IRQ_N-1:0] code_onehot(input logic [IRQ_CODE_W-1:0] code);
      logic [IRQ_N-1:0] w_mask;
      w_mask       = '0;
      w_mask[code] = 1'b1;
      return w_mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/irq_pending_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_pending_arbiter_if
// Brief    : Request/mask inputs, valid/ready code handshake and status
//            outputs of the interrupt pending arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface irq_pending_arbiter_if
   import irq_pkg::*;
#(
   parameter int N      = IRQ_N,
   parameter int CODE_W = IRQ_CODE_W
) ();

   logic [N-1:0]      req;
   logic [N-1:0]      mask;
   logic              irq_valid;
   logic [CODE_W-1:0] irq_code;
   logic              irq_ready;
   logic [N-1:0]      pending;
   logic [7:0]        drop_cnt;

   // Requester / consumer side.
   modport master (
      output req,
      output mask,
      output irq_ready,
      input  irq_valid,
      input  irq_code,
      input  pending,
      input  drop_cnt
   );

   // Arbiter side.
   modport slave (
      input  req,
      input  mask,
      input  irq_ready,
      output irq_valid,
      output irq_code,
      output pending,
      output drop_cnt
   );

endinterface
`default_nettype wire

// File: rtl/irq_pending_arbiter_prio_enc8.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc8
// Brief    : Combinational 8-to-3 priority encoder, bit 7 highest, with an
//            any-valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module prio_enc8
   import irq_pkg::*;
(
   input  logic [IRQ_N-1:0]      i_vec,
   output logic [IRQ_CODE_W-1:0] o_code,
   output logic                  o_any_valid
);

   // Ascending scan so the highest set bit is the last one written.
   always_comb begin
      o_code      = '0;
      o_any_valid = 1'b0;
      for (int i = 0; i < IRQ_N; i++) begin
         if (i_vec[i]) begin
            o_code      = IRQ_CODE_W'(i);
            o_any_valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/irq_pending_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : irq_pending_arbiter
// Brief    : Captures eight request lines into sticky pending bits, masks
//            them and offers the highest-priority one as a registered 3-bit
//            code over valid/ready; the accepted line's pending bit clears.
//            Build option IRQ_EDGE_DETECT_EN: rising-edge events instead of
//            level events.
// Revision : 1.0 - initial release
// ============================================================================
module irq_pending_arbiter
   import irq_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   irq_pending_arbiter_if.slave  bus
);

   localparam logic [7:0] c_DROP_MAX = 8'hFF;

   irq_state_e            r_state;
   irq_state_e            w_state_nxt;
   logic [IRQ_CODE_W-1:0] r_code;
   logic [IRQ_CODE_W-1:0] w_code_nxt;
   logic [IRQ_N-1:0]      r_pending;
   logic [7:0]            r_drop_cnt;

   logic [IRQ_N-1:0]      w_event;
   logic [IRQ_N-1:0]      w_code_oh;
   logic [IRQ_N-1:0]      w_clr;
   logic [IRQ_N-1:0]      w_cand;
   logic [IRQ_N-1:0]      w_next;
   logic [IRQ_CODE_W-1:0] w_cand_code;
   logic [IRQ_CODE_W-1:0] w_next_code;
   logic                  w_cand_any;
   logic                  w_next_any;
   logic                  w_hs;
   logic                  w_drop;

`ifdef IRQ_EDGE_DETECT_EN
   logic [IRQ_N-1:0] r_req_q;

   // Previous-cycle request levels so only rising edges count as events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_req_q <= '0;
      else        r_req_q <= bus.req;
   end

   assign w_event = bus.req & ~r_req_q;
`else
   assign w_event = bus.req;
`endif

   assign w_hs      = (r_state == OFFER) && bus.irq_ready;
   assign w_code_oh = code_onehot(r_code);
   assign w_clr     = w_hs ? w_code_oh : '0;
   assign w_cand    = r_pending & bus.mask;
   // Candidates left once the code being accepted is removed.
   assign w_next    = w_cand & ~w_code_oh;
   assign w_drop    = |(w_event & r_pending & ~w_clr);

   prio_enc8 u_enc_cand (
      .i_vec       (w_cand),
      .o_code      (w_cand_code),
      .o_any_valid (w_cand_any)
   );

   prio_enc8 u_enc_next (
      .i_vec       (w_next),
      .o_code      (w_next_code),
      .o_any_valid (w_next_any)
   );

   // Sticky pending bits; a new event beats a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pending <= '0;
      else        r_pending <= w_event | (r_pending & ~w_clr);
   end

   // Saturating count of cycles in which at least one event was lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                r_drop_cnt <= '0;
      else if (w_drop && r_drop_cnt != c_DROP_MAX) r_drop_cnt <= r_drop_cnt + 8'd1;
   end

   // Offer state and the frozen code register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_code  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_code  <= w_code_nxt;
      end
   end

   // Next offer: load on entry, reload on accept for bubble-free grants.
   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      case (r_state)
         IDLE: begin
            if (w_cand_any) begin
               w_state_nxt = OFFER;
               w_code_nxt  = w_cand_code;
            end
         end
         OFFER: begin
            if (w_hs) begin
               if (w_next_any) w_code_nxt  = w_next_code;
               else            w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.irq_valid = (r_state == OFFER);
   assign bus.irq_code  = r_code;
   assign bus.pending   = r_pending;
   assign bus.drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_pending_arbiter
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            random traffic against a behavioural model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_pending_arbiter;

   logic clk;
   logic rst_n;

   irq_pending_arbiter_if bus ();

   irq_pending_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state.
   bit [7:0] m_pend;
   bit       m_valid;
   int       m_code;
   bit [7:0] m_reqq;
   int       m_drop;

   typedef struct {
      logic [7:0] req;
      logic [7:0] mask;
      logic       rdy;
      logic       ev;
      logic [2:0] ec;
      logic [7:0] ep;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [7:0] req, input logic [7:0] mask,
                               input logic rdy, input logic ev,
                               input logic [2:0] ec, input logic [7:0] ep);
      vec_t v;
      v.req = req; v.mask = mask; v.rdy = rdy; v.ev = ev; v.ec = ec; v.ep = ep;
      return v;
   endfunction

   function automatic int highest(input bit [7:0] v);
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = '0; m_valid = 0; m_code = 0; m_reqq = '0; m_drop = 0;
   endtask

   // One rising edge of the arbiter described from its rules.
   task automatic model_step(input bit [7:0] req, input bit [7:0] mask, input bit rdy);
      bit [7:0] ev, clr, cand, rest;
      bit       hs;
`ifdef IRQ_EDGE_DETECT_EN
      ev = req & ~m_reqq;
`else
      ev = req;
`endif
      hs   = m_valid && rdy;
      clr  = hs ? (8'd1 << m_code) : 8'd0;
      cand = m_pend & mask;
      if (!m_valid) begin
         if (cand != 0) begin m_valid = 1; m_code = highest(cand); end
      end else if (hs) begin
         rest = cand & ~(8'd1 << m_code);
         if (rest != 0) m_code = highest(rest);
         else           m_valid = 0;
      end
      if ((ev & m_pend & ~clr) != 0 && m_drop < 255) m_drop++;
      m_pend = ev | (m_pend & ~clr);
      m_reqq = req;
   endtask

   task automatic drive(input logic [7:0] req, input logic [7:0] mask, input logic rdy);
      bus.req = req; bus.mask = mask; bus.irq_ready = rdy;
   endtask

   // Advance one clock; model follows the same edge, outputs sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      model_step(bus.req, bus.mask, bus.irq_ready);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, 32'(bus.irq_valid), 32'(m_valid));
      if (m_valid) chk({tag, ".code"}, 32'(bus.irq_code), 32'(m_code));
      chk({tag, ".pending"}, 32'(bus.pending), 32'(m_pend));
      chk({tag, ".drop"}, 32'(bus.drop_cnt), 32'(m_drop));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      drive(8'h00, 8'hFF, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state held for ten cycles with no requests.
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("rst.valid", 32'(bus.irq_valid), 32'd0);
         chk("rst.code", 32'(bus.irq_code), 32'd0);
         chk("rst.pending", 32'(bus.pending), 32'd0);
         chk("rst.drop", 32'(bus.drop_cnt), 32'd0);
      end

      // Directed vectors: inputs applied, one edge, expected outputs.
      tbl.push_back(mk(8'h05, 8'hFF, 1, 0, 0, 8'h05));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 1, 2, 8'h05));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 8'h01));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h00));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h00));
      tbl.push_back(mk(8'hFF, 8'hFF, 0, 0, 0, 8'hFF));
      tbl.push_back(mk(8'h00, 8'hFF, 0, 1, 7, 8'hFF));
      tbl.push_back(mk(8'h00, 8'hFF, 0, 1, 7, 8'hFF));
      tbl.push_back(mk(8'h00, 8'hFF, 0, 1, 7, 8'hFF));
      tbl.push_back(mk(8'h00, 8'hFF, 0, 1, 7, 8'hFF));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 1, 6, 8'h7F));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 1, 5, 8'h3F));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 1, 4, 8'h1F));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 1, 3, 8'h0F));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 1, 2, 8'h07));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 1, 1, 8'h03));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 8'h01));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h00));
      tbl.push_back(mk(8'h80, 8'h7F, 1, 0, 0, 8'h80));
      tbl.push_back(mk(8'h40, 8'h7F, 1, 0, 0, 8'hC0));
      tbl.push_back(mk(8'h00, 8'h7F, 1, 1, 6, 8'hC0));
      tbl.push_back(mk(8'h00, 8'h7F, 1, 0, 0, 8'h80));
      tbl.push_back(mk(8'h00, 8'h7F, 1, 0, 0, 8'h80));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 1, 7, 8'h80));
      tbl.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h00));
      tbl.push_back(mk(8'h08, 8'hFF, 0, 0, 0, 8'h08));
      tbl.push_back(mk(8'h00, 8'hFF, 0, 1, 3, 8'h08));
      tbl.push_back(mk(8'h00, 8'h00, 0, 1, 3, 8'h08));
      tbl.push_back(mk(8'h00, 8'h00, 1, 0, 0, 8'h00));

      foreach (tbl[k]) begin
         drive(tbl[k].req, tbl[k].mask, tbl[k].rdy);
         tick();
         chk($sformatf("vec%0d.valid", k), 32'(bus.irq_valid), 32'(tbl[k].ev));
         if (tbl[k].ev) chk($sformatf("vec%0d.code", k), 32'(bus.irq_code), 32'(tbl[k].ec));
         chk($sformatf("vec%0d.pending", k), 32'(bus.pending), 32'(tbl[k].ep));
         chk($sformatf("vec%0d.drop", k), 32'(bus.drop_cnt), 32'd0);
      end

      // Lost event on line 3, then a new event on the cycle its ack lands.
      drive(8'h08, 8'hFF, 0); tick(); check_model("drop1");
      drive(8'h00, 8'hFF, 0); tick(); check_model("drop2");
      drive(8'h08, 8'hFF, 0); tick(); check_model("drop3");
      chk("drop.count", 32'(bus.drop_cnt), 32'd1);
      drive(8'h00, 8'hFF, 0); tick(); check_model("drop4");
      drive(8'h08, 8'hFF, 1); tick(); check_model("setwins");
      chk("setwins.pend3", 32'(bus.pending[3]), 32'd1);
      drive(8'h00, 8'hFF, 0); tick(); check_model("reoffer");
      chk("reoffer.valid", 32'(bus.irq_valid), 32'd1);
      chk("reoffer.code", 32'(bus.irq_code), 32'd3);
      drive(8'h00, 8'hFF, 1); tick(); check_model("reoffer.ack");

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [7:0] r, m;
         r = ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
         m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         drive(r, m, ($urandom_range(0, 2) != 0));
         tick();
         check_model("rand");
      end

      // Drain, then hold a masked line high to exercise drop saturation.
      drive(8'h00, 8'hFF, 1);
      repeat (10) tick();
      check_model("drain");
      drive(8'h01, 8'h00, 0);
      repeat (300) tick();
      check_model("sat");
`ifndef IRQ_EDGE_DETECT_EN
      chk("sat.drop", 32'(bus.drop_cnt), 32'd255);
`endif
      drive(8'h00, 8'hFF, 1);
      repeat (3) tick();
      check_model("sat.drain");

      // Asynchronous reset in the middle of an offer.
      drive(8'h7B, 8'hFF, 0); tick(); check_model("ar.load");
      drive(8'h00, 8'hFF, 0); tick(); check_model("ar.offer");
      chk("ar.pend", 32'(bus.pending), 32'h7B);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.valid0", 32'(bus.irq_valid), 32'd0);
      chk("ar.pend0", 32'(bus.pending), 32'd0);
      chk("ar.drop0", 32'(bus.drop_cnt), 32'd0);
      model_reset();
      drive(8'hFF, 8'hFF, 1);
      repeat (2) @(posedge clk);
      #1;
      drive(8'h00, 8'hFF, 1);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_model("ar.quiet");
         chk("ar.quiet.valid", 32'(bus.irq_valid), 32'd0);
      end
      drive(8'h10, 8'hFF, 0); tick(); check_model("ar.new");
      drive(8'h00, 8'hFF, 0); tick(); check_model("ar.new.offer");
      chk("ar.new.valid", 32'(bus.irq_valid), 32'd1);
      chk("ar.new.code", 32'(bus.irq_code), 32'd4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
